// File: rtl/digit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : digit_pkg
// Description : Shared types for the digit counter / digit streamer pair.
// Revision    : 1.0 - initial release
// ============================================================================
package digit_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        STREAM  = 2'd2
    } state_t;

    localparam int DEFAULT_DIGITS = 10;

    typedef logic [3:0] bcd_nib_t;

endpackage : digit_pkg
`default_nettype wire

// File: rtl/bcd_adjust.sv
`default_nettype none
// ============================================================================
// Module      : bcd_adjust
// Description : Double-dabble nibble correction, adds 3 when nibble >= 5.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_adjust
    import digit_pkg::*;
(
    input  bcd_nib_t i_nib,
    output bcd_nib_t o_nib
);

    always_comb begin
        o_nib = i_nib;
        if (i_nib >= 4'd5) begin
            o_nib = i_nib + 4'd3;
        end
    end

endmodule : bcd_adjust
`default_nettype wire

// File: rtl/digit_streamer.sv
`default_nettype none
// ============================================================================
// Module      : digit_streamer
// Description : Binary to BCD via iterative double dabble, then streams the
//               low-order digits MSD first over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_streamer
    import digit_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] n,
    input  logic [7:0]       count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       digit,
    output logic             out_last,
    output logic             busy
);

    localparam int c_CW = $clog2(WIDTH + 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [WIDTH-1:0]        r_bin;
    bcd_nib_t [DIGITS-1:0]   r_bcd;
    bcd_nib_t [DIGITS-1:0]   w_adj;
    logic [c_CW-1:0]         r_cnt;
    logic [3:0]              r_ec;
    logic [3:0]              r_idx;
    logic [3:0]              w_ec;
    logic [DIGITS*4+WIDTH-1:0] w_shift;
    logic                    w_accept;
    logic                    w_pop;
    logic                    w_last_bit;

    // Zero count still means "print 0"; oversize counts clamp to register depth
    always_comb begin
        w_ec = count[3:0];
        if (count == 8'd0) begin
            w_ec = 4'd1;
        end else if (count > 8'(DIGITS)) begin
            w_ec = 4'(DIGITS);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_adjust u_adj (
            .i_nib (r_bcd[g]),
            .o_nib (w_adj[g])
        );
    end

    assign w_shift    = {w_adj, r_bin} << 1;
    assign w_accept   = (r_state == IDLE) && in_valid;
    assign w_pop      = (r_state == STREAM) && out_ready;
    assign w_last_bit = (r_cnt == c_CW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        digit       = 4'd0;
        out_last    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = CONVERT;
                end
            end
            CONVERT: begin
                busy = 1'b1;
                if (w_last_bit) begin
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                digit     = r_bcd[r_idx];
                out_last  = (r_idx == 4'd0);
                if (out_ready && (r_idx == 4'd0)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
            r_ec  <= '0;
            r_idx <= '0;
        end else begin
            if (w_accept) begin
                r_bin <= n;
                r_bcd <= '0;
                r_cnt <= c_CW'(WIDTH);
                r_ec  <= w_ec;
            end else if (r_state == CONVERT) begin
                r_bcd <= w_shift[DIGITS*4+WIDTH-1:WIDTH];
                r_bin <= w_shift[WIDTH-1:0];
                r_cnt <= r_cnt - c_CW'(1);
                if (w_last_bit) begin
                    r_idx <= r_ec - 4'd1;
                end
            end else if (w_pop && (r_idx != 4'd0)) begin
                r_idx <= r_idx - 4'd1;
            end
        end
    end

endmodule : digit_streamer
`default_nettype wire

// File: tb/tb_digit_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_streamer
// Description : Scoreboard bench for digit_streamer with a decimal reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_streamer;

    localparam int c_WIDTH  = 32;
    localparam int c_DIGITS = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [c_WIDTH-1:0] n = '0;
    logic [7:0]        count = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [3:0]        digit;
    logic              out_last;
    logic              busy;

    int total = 0;
    int bad   = 0;
    logic [4:0] q[$];
    bit  rand_ready = 1'b0;

    digit_streamer #(.WIDTH(c_WIDTH), .DIGITS(c_DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n         (n),
        .count     (count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .digit     (digit),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decimal digits of the value, least-significant ec of them, MSD first
    task automatic push_expected(input logic [31:0] val, input logic [7:0] cnt);
        int ec;
        longint p;
        ec = (cnt == 0) ? 1 : ((cnt > c_DIGITS) ? c_DIGITS : int'(cnt));
        for (int i = ec - 1; i >= 0; i--) begin
            p = 1;
            for (int k = 0; k < i; k++) p = p * 10;
            q.push_back({(i == 0), 4'((longint'(val) / p) % 10)});
        end
    endtask

    task automatic send(input logic [31:0] val, input logic [7:0] cnt);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("send_ready_timeout", longint'(in_ready), 1);
        push_expected(val, cnt);
        n = val;
        count = cnt;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        @(negedge clk);
        while (!(in_ready && q.size() == 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("done_timeout", longint'(in_ready && q.size() == 0), 1);
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("valid_timeout", longint'(out_valid), 1);
    endtask

    // Monitor: scoreboard pops, idle-zero outputs, and stall stability
    logic       stall = 1'b0;
    logic [4:0] held  = '0;
    always @(negedge clk) begin
        if (!rst) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("hold_valid", longint'(out_valid), 1);
                check("hold_digit", longint'({out_last, digit}), longint'(held));
            end
            if (!out_valid) begin
                check("idle_outputs", longint'({out_last, digit}), 0);
            end else if (out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_digit", longint'({out_last, digit}), -1);
                end else begin
                    check("digit", longint'({out_last, digit}), longint'(q.pop_front()));
                end
            end
            stall = out_valid && !out_ready;
            held  = {out_last, digit};
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2 if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        logic [31:0] rv;

        #1;
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_digit", longint'({out_last, digit}), 0);
        #20 rst = 1'b1;

        // Latency and in_ready return for 12345 / 5
        send(32'd12345, 8'd5);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        check("latency", cyc, c_WIDTH);
        while (!(out_valid && out_last) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #1 check("in_ready_return", longint'(in_ready), 1);
        wait_done();

        send(32'd0, 8'd0);              wait_done();
        send(32'd4294967295, 8'd10);    wait_done();
        send(32'd12345, 8'd3);          wait_done();
        send(32'd12345, 8'd15);         wait_done();

        // Backpressure on digit 0 of 907, with an ignored in_valid pulse
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(32'd907, 8'd3);
        wait_valid();
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        n = 32'd555;
        count = 8'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_digit", longint'({out_last, digit}), 0);
            check("bp_in_ready", longint'(in_ready), 0);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b1;
        wait_done();
        cyc = 0;
        for (int i = 0; i < c_WIDTH + 5; i++) begin
            @(negedge clk);
            if (out_valid) cyc++;
        end
        check("ignored_input", cyc, 0);

        // Reset during CONVERT
        send(32'd123456, 8'd6);
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_conv_in_ready", longint'(in_ready), 1);
        check("abort_conv_busy", longint'(busy), 0);
        q.delete();
        @(negedge clk);
        #1 rst = 1'b1;

        // Reset during STREAM
        send(32'd98765, 8'd5);
        wait_valid();
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_str_out_valid", longint'(out_valid), 0);
        check("abort_str_digit", longint'({out_last, digit}), 0);
        check("abort_str_busy", longint'(busy), 0);
        q.delete();
        @(negedge clk);
        #1 rst = 1'b1;
        send(32'd42, 8'd2);
        wait_done();

        // Randomized values and counts under random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 2))
                0: rv = $urandom;
                1: rv = $urandom_range(0, 999);
                default: rv = $urandom_range(0, 99999);
            endcase
            send(rv, 8'($urandom_range(0, 16)));
        end
        wait_done();
        rand_ready = 1'b0;
        #2 out_ready = 1'b1;

        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_digit_streamer
`default_nettype wire
